// File: rtl/butterfly_pipe_if.sv
// Operand/result bundle for butterfly_pipe: input handshake, twiddle, result handshake
// and the sticky saturation flag with its clear.
interface butterfly_pipe_if #(
    parameter int DW  = 16,
    parameter int TWW = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  xr;
    logic signed [DW-1:0]  xi;
    logic signed [DW-1:0]  yr;
    logic signed [DW-1:0]  yi;
    logic signed [TWW-1:0] wr;
    logic signed [TWW-1:0] wi;
    logic                  scale;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [DW-1:0]  out0_r;
    logic signed [DW-1:0]  out0_i;
    logic signed [DW-1:0]  out1_r;
    logic signed [DW-1:0]  out1_i;
    logic                  ovf;
    logic                  ovf_clr;

    modport master (
        output in_valid, xr, xi, yr, yi, wr, wi, scale, out_ready, ovf_clr,
        input  in_ready, out_valid, out0_r, out0_i, out1_r, out1_i, ovf
    );

    modport slave (
        input  in_valid, xr, xi, yr, yi, wr, wi, scale, out_ready, ovf_clr,
        output in_ready, out_valid, out0_r, out0_i, out1_r, out1_i, ovf
    );
endinterface

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly, three register stages: products, rounded twiddle product t,
// then x +/- t with optional halving and saturation. One global stall enable.
module butterfly_pipe #(
    parameter int DW  = 16,
    parameter int TWW = 16
) (
    input logic              clk,
    input logic              rst_n,
    butterfly_pipe_if.slave  bus
);
    localparam int PW = DW + TWW;
    localparam int TW = DW + 2;

    localparam logic signed [PW:0]   RND  = (PW+1)'(1) << (TWW-2);
    localparam logic signed [TW-1:0] SMAX = TW'((1 << (DW-1)) - 1);
    localparam logic signed [TW-1:0] SMIN = TW'(-(1 << (DW-1)));
    localparam logic signed [TW-1:0] ONE  = TW'(1);

    logic en;

    logic                 v1;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [DW-1:0] x1r, x1i;
    logic                 sc1;

    logic                 v2;
    logic signed [TW-1:0] t2r, t2i;
    logic signed [DW-1:0] x2r, x2i;
    logic                 sc2;

    logic signed [PW:0]   acc_r, acc_i;
    logic signed [TW-1:0] t_r, t_i;
    logic signed [TW-1:0] s0r, s0i, s1r, s1i;
    logic [DW:0]          c0r, c0i, c1r, c1i;
    logic                 sat_hit;

    // Optional halving with round-half-up, then clamp; MSB of the result flags a clamp.
    function automatic logic [DW:0] finish(input logic signed [TW-1:0] s, input logic sc);
        logic signed [TW-1:0] v;
        v = sc ? ((s + ONE) >>> 1) : s;
        if (v > SMAX)
            finish = {1'b1, SMAX[DW-1:0]};
        else if (v < SMIN)
            finish = {1'b1, SMIN[DW-1:0]};
        else
            finish = {1'b0, v[DW-1:0]};
    endfunction

    assign en           = bus.out_ready || !bus.out_valid;
    assign bus.in_ready = en;

    // Sums are carried at PW+1 bits so the rounded shift never wraps before truncation.
    assign acc_r = (PW+1)'(p_rr) - (PW+1)'(p_ii) + RND;
    assign acc_i = (PW+1)'(p_ri) + (PW+1)'(p_ir) + RND;
    assign t_r   = TW'(acc_r >>> (TWW-1));
    assign t_i   = TW'(acc_i >>> (TWW-1));

    assign s0r = TW'(x2r) + t2r;
    assign s0i = TW'(x2i) + t2i;
    assign s1r = TW'(x2r) - t2r;
    assign s1i = TW'(x2i) - t2i;

    assign c0r = finish(s0r, sc2);
    assign c0i = finish(s0i, sc2);
    assign c1r = finish(s1r, sc2);
    assign c1i = finish(s1i, sc2);

    assign sat_hit = en && v2 && (c0r[DW] || c0i[DW] || c1r[DW] || c1i[DW]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1            <= 1'b0;
            p_rr          <= '0;
            p_ii          <= '0;
            p_ri          <= '0;
            p_ir          <= '0;
            x1r           <= '0;
            x1i           <= '0;
            sc1           <= 1'b0;
            v2            <= 1'b0;
            t2r           <= '0;
            t2i           <= '0;
            x2r           <= '0;
            x2i           <= '0;
            sc2           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out0_r    <= '0;
            bus.out0_i    <= '0;
            bus.out1_r    <= '0;
            bus.out1_i    <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            if (en) begin
                v1            <= bus.in_valid;
                v2            <= v1;
                bus.out_valid <= v2;
                if (bus.in_valid) begin
                    p_rr <= PW'(bus.yr) * PW'(bus.wr);
                    p_ii <= PW'(bus.yi) * PW'(bus.wi);
                    p_ri <= PW'(bus.yr) * PW'(bus.wi);
                    p_ir <= PW'(bus.yi) * PW'(bus.wr);
                    x1r  <= bus.xr;
                    x1i  <= bus.xi;
                    sc1  <= bus.scale;
                end
                if (v1) begin
                    t2r <= t_r;
                    t2i <= t_i;
                    x2r <= x1r;
                    x2i <= x1i;
                    sc2 <= sc1;
                end
                if (v2) begin
                    bus.out0_r <= c0r[DW-1:0];
                    bus.out0_i <= c0i[DW-1:0];
                    bus.out1_r <= c1r[DW-1:0];
                    bus.out1_i <= c1i[DW-1:0];
                end
            end
            // A fresh clamp outranks a simultaneous clear.
            bus.ovf <= sat_hit || (bus.ovf && !bus.ovf_clr);
        end
    end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe at DW = TWW = 16; every expected result is hand-derived.
module tb_butterfly_pipe;
    localparam int DW  = 16;
    localparam int TWW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    butterfly_pipe_if #(.DW(DW), .TWW(TWW)) bif ();

    butterfly_pipe #(.DW(DW), .TWW(TWW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    // Stream vectors: x, y, W, scale and the expected {out0_r,out0_i,out1_r,out1_i}.
    int          v_xr [5] = '{10, -100, 0, 1000, 5};
    int          v_xi [5] = '{20, 50, 0, -1000, -5};
    int          v_yr [5] = '{30, 7, 100, 500, -6};
    int          v_yi [5] = '{40, -3, 200, -500, 6};
    int          v_wr [5] = '{32767, -32768, 0, 32767, -32768};
    int          v_wi [5] = '{0, 0, 32767, 0, 0};
    logic        v_sc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] v_exp[5];

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    function automatic logic [63:0] outs();
        return {bif.out0_r, bif.out0_i, bif.out1_r, bif.out1_i};
    endfunction

    task automatic idle_inputs();
        bif.in_valid  = 1'b0;
        bif.xr        = '0;
        bif.xi        = '0;
        bif.yr        = '0;
        bif.yi        = '0;
        bif.wr        = '0;
        bif.wi        = '0;
        bif.scale     = 1'b0;
        bif.out_ready = 1'b1;
        bif.ovf_clr   = 1'b0;
    endtask

    task automatic drive_set(input int xr, input int xi, input int yr, input int yi,
                             input int wr, input int wi, input logic sc);
        bif.xr       = DW'(xr);
        bif.xi       = DW'(xi);
        bif.yr       = DW'(yr);
        bif.yi       = DW'(yi);
        bif.wr       = TWW'(wr);
        bif.wi       = TWW'(wi);
        bif.scale    = sc;
        bif.in_valid = 1'b1;
    endtask

    // Push one set with out_ready high; report out_valid at the three following samples.
    task automatic single(input int xr, input int xi, input int yr, input int yi,
                          input int wr, input int wi, input logic sc,
                          output logic [2:0] vseen, output logic [63:0] data,
                          output logic ovf_seen);
        @(negedge clk);
        drive_set(xr, xi, yr, yi, wr, wi, sc);
        @(negedge clk);
        bif.in_valid = 1'b0;
        vseen[0] = bif.out_valid;
        @(negedge clk);
        vseen[1] = bif.out_valid;
        @(negedge clk);
        vseen[2] = bif.out_valid;
        data     = outs();
        ovf_seen = bif.ovf;
    endtask

    task automatic test_reset();
        idle_inputs();
        #12;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got valid=%b ovf=%b want 0 0", bif.out_valid, bif.ovf);
        end
        n_checks++;
        if (outs() !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", outs());
        end
        n_checks++;
        if (bif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", bif.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [2:0]  vs;
        logic [63:0] d;
        logic        o;
        single(1000, 0, 2000, 0, 32767, 0, 1'b0, vs, d, o);
        n_checks++;
        if (vs !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_latency got %b want 100", vs);
        end
        n_checks++;
        if (d !== pack4(3000, 0, -1000, 0)) begin
            n_fail++;
            $display("FAIL basic_data got %h want %h", d, pack4(3000, 0, -1000, 0));
        end
        n_checks++;
        if (o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ovf got %b want 0", o);
        end
    endtask

    task automatic test_neg_twiddle();
        logic [2:0]  vs;
        logic [63:0] d;
        logic        o;
        single(1000, 0, 2000, 0, -32768, 0, 1'b0, vs, d, o);
        n_checks++;
        if (d !== pack4(-1000, 0, 3000, 0)) begin
            n_fail++;
            $display("FAIL negtw_data got %h want %h", d, pack4(-1000, 0, 3000, 0));
        end
    endtask

    task automatic test_saturation();
        logic [2:0]  vs;
        logic [63:0] d;
        logic        o;
        single(32767, 0, 32767, 0, -32768, 0, 1'b0, vs, d, o);
        n_checks++;
        if (d !== pack4(0, 0, 32767, 0) || o !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_unscaled got %h ovf=%b want %h ovf=1", d, o, pack4(0, 0, 32767, 0));
        end
        @(negedge clk);
        bif.ovf_clr = 1'b1;
        @(negedge clk);
        bif.ovf_clr = 1'b0;
        n_checks++;
        if (bif.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear got %b want 0", bif.ovf);
        end
        single(32767, 0, 32767, 0, -32768, 0, 1'b1, vs, d, o);
        n_checks++;
        if (d !== pack4(0, 0, 32767, 0) || o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_scaled got %h ovf=%b want %h ovf=0", d, o, pack4(0, 0, 32767, 0));
        end
    endtask

    task automatic test_back_to_back();
        int tx = 0;
        int rx = 0;
        int stall = 0;
        int blocked = 0;
        int cyc = 0;
        logic acc;
        while (rx < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rx >= 2 && stall < 4) begin
                bif.out_ready = 1'b0;
                stall++;
            end else begin
                bif.out_ready = 1'b1;
            end
            if (tx < 5)
                drive_set(v_xr[tx], v_xi[tx], v_yr[tx], v_yi[tx], v_wr[tx], v_wi[tx], v_sc[tx]);
            else
                bif.in_valid = 1'b0;
            #1;
            acc = bif.in_valid && bif.in_ready;
            if (bif.out_valid) begin
                n_checks++;
                if (outs() !== v_exp[rx]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d got %h want %h", rx, outs(), v_exp[rx]);
                end
                if (!bif.out_ready) begin
                    blocked++;
                    n_checks++;
                    if (bif.in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_in_ready_stalled got %b want 0", bif.in_ready);
                    end
                end else begin
                    rx++;
                end
            end
            if (acc)
                tx++;
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        n_checks++;
        if (rx != 5) begin
            n_fail++;
            $display("FAIL b2b_timeout got %0d results want 5", rx);
        end
        n_checks++;
        if (blocked != 4) begin
            n_fail++;
            $display("FAIL b2b_stall_cycles got %0d want 4", blocked);
        end
    endtask

    task automatic test_ovf_clr();
        @(negedge clk);
        drive_set(32767, 0, 32767, 0, -32768, 0, 1'b0);
        @(negedge clk);
        bif.in_valid = 1'b0;
        @(negedge clk);
        bif.ovf_clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bif.ovf !== 1'b1 || bif.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovfclr_collide got ovf=%b valid=%b want 1 1", bif.ovf, bif.out_valid);
        end
        @(negedge clk);
        bif.ovf_clr = 1'b0;
        n_checks++;
        if (bif.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovfclr_plain got %b want 0", bif.ovf);
        end
    endtask

    task automatic test_reset_midflight();
        logic [2:0]  vs;
        logic [63:0] d;
        logic        o;
        int          stale = 0;
        @(negedge clk);
        drive_set(32767, 0, 32767, 0, -32768, 0, 1'b0);
        @(negedge clk);
        drive_set(v_xr[1], v_xi[1], v_yr[1], v_yi[1], v_wr[1], v_wi[1], v_sc[1]);
        @(negedge clk);
        bif.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bif.out_valid !== 1'b1 || bif.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup got valid=%b ovf=%b want 1 1", bif.out_valid, bif.ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bif.out_valid !== 1'b0 || bif.ovf !== 1'b0 || outs() !== 64'h0) begin
            n_fail++;
            $display("FAIL midrst_async got valid=%b ovf=%b data=%h want 0 0 0",
                     bif.out_valid, bif.ovf, outs());
        end
        n_checks++;
        if (bif.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready got %b want 1", bif.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bif.out_valid !== 1'b0)
                stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midrst_stale got %0d valid cycles want 0", stale);
        end
        single(v_xr[2], v_xi[2], v_yr[2], v_yi[2], v_wr[2], v_wi[2], v_sc[2], vs, d, o);
        n_checks++;
        if (vs !== 3'b100 || d !== v_exp[2]) begin
            n_fail++;
            $display("FAIL midrst_first got valid=%b data=%h want 100 %h", vs, d, v_exp[2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v_exp[0] = pack4(40, 60, -20, -20);
        v_exp[1] = pack4(-107, 53, -93, 47);
        v_exp[2] = pack4(-200, 100, 200, -100);
        v_exp[3] = pack4(750, -750, 250, -250);
        v_exp[4] = pack4(6, -5, 0, 1);
        test_reset();
        test_basic();
        test_neg_twiddle();
        test_saturation();
        test_back_to_back();
        test_ovf_clr();
        test_reset_midflight();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
